// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter.
package piso_pkg;

  // Frame FSM: waiting for a word, or clocking one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT);

  // Bit-counter width for a given frame length; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_tx_d_ff.sv
// Single-bit storage cell with asynchronous active-high clear.
module d_ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Capture d each rising edge; clear immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter. A word accepted on a load edge is
// emitted one bit per cycle starting the following cycle. ready rises again
// during the last bit so a new load at that edge gives a gapless stream.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load,
  output logic             ready,
  output logic             serial_out,
  output logic             frame,
  output logic             done
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_shift_q;
  logic [WIDTH-1:0] w_shift_d;
  logic [WIDTH-1:0] w_shifted;
  logic             w_out_bit;
  logic             w_ready;
  logic             w_accept;

  // The output end of the register depends on bit order.
  assign w_out_bit = MSB_FIRST ? w_shift_q[WIDTH-1] : w_shift_q[0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Bit counter: index of the bit currently on serial_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_next;
  end

  // Next state, counter update and outputs. serial_out/frame/done depend
  // only on state, counter and shift flops; load only steers next state.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ready      = 1'b0;
    frame        = 1'b0;
    serial_out   = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (load) begin
          w_state_next = SHIFT;
          w_cnt_next   = '0;
        end
      end
      SHIFT: begin
        frame      = 1'b1;
        serial_out = w_out_bit;
        if (r_cnt == LAST_CNT) begin
          // Last bit: either finish or restart with the next word.
          done         = 1'b1;
          w_ready      = 1'b1;
          w_cnt_next   = '0;
          w_state_next = load ? SHIFT : IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign ready    = w_ready;
  assign w_accept = load & w_ready;

  // One storage cell per bit, each fed by a load / shift / hold mux.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_end
          assign w_shifted[gi] = 1'b0;
        end else begin : g_mid
          assign w_shifted[gi] = w_shift_q[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_end
          assign w_shifted[gi] = 1'b0;
        end else begin : g_mid
          assign w_shifted[gi] = w_shift_q[gi+1];
        end
      end

      assign w_shift_d[gi] = w_accept           ? parallel_in[gi] :
                             (r_state == SHIFT) ? w_shifted[gi]   :
                                                  w_shift_q[gi];

      d_ff u_bit (
        .clk (clk),
        .rst (rst),
        .d   (w_shift_d[gi]),
        .q   (w_shift_q[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one LSB-first and one MSB-first instance
// share the same clock, reset and stimulus.
module tb_piso_tx;
  import piso_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] parallel_in;
  logic       load;
  logic       ready_l, serial_l, frame_l, done_l;
  logic       ready_m, serial_m, frame_m, done_m;

  int n_checks = 0;
  int n_fail   = 0;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .parallel_in(parallel_in), .load(load),
    .ready(ready_l), .serial_out(serial_l), .frame(frame_l), .done(done_l)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .parallel_in(parallel_in), .load(load),
    .ready(ready_m), .serial_out(serial_m), .frame(frame_m), .done(done_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle; inputs change and outputs are sampled at negedges.
  task automatic step();
    @(negedge clk);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [15:0] stream;
    logic [7:0]  words [0:4];

    rst         = 1'b1;
    load        = 1'b0;
    parallel_in = 8'h00;

    // Reset state, and loads ignored while reset is held.
    step();
    check_val("rst_ready", ready_l, 1);
    check_val("rst_frame", frame_l, 0);
    check_val("rst_serial", serial_l, 0);
    check_val("rst_done", done_l, 0);
    load = 1'b1; parallel_in = 8'hFF;
    step(); step();
    check_val("rst_load_frame", frame_l, 0);
    check_val("rst_load_ready", ready_l, 1);
    load = 1'b0;
    rst  = 1'b0;
    step();
    check_val("idle_frame", frame_l, 0);
    $display("reset checks done");

    // Single word 0x0F on both bit orders.
    d = 8'h0F;
    parallel_in = d; load = 1'b1;
    step();
    load = 1'b0; parallel_in = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      check_val($sformatf("t1_lsb_bit%0d", k), serial_l, d[k-1]);
      check_val($sformatf("t1_msb_bit%0d", k), serial_m, d[8-k]);
      check_val($sformatf("t1_frame%0d", k), frame_l, 1);
      check_val($sformatf("t1_done%0d", k), done_l, (k == 8));
      check_val($sformatf("t1_ready%0d", k), ready_l, (k == 8));
      step();
    end
    check_val("t1_frame_end", frame_l, 0);
    check_val("t1_ready_end", ready_l, 1);
    check_val("t1_serial_end", serial_l, 0);
    $display("frame 0x%02h sent, lsb and msb order", d);

    // Back-to-back 0x01 then 0x80 loaded during the last bit.
    stream = {8'h80, 8'h01};
    parallel_in = 8'h01; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      check_val($sformatf("t2_bit%0d", k), serial_l, stream[k-1]);
      check_val($sformatf("t2_frame%0d", k), frame_l, 1);
      check_val($sformatf("t2_done%0d", k), done_l, (k == 8 || k == 16));
      if (k == 8) begin
        parallel_in = 8'h80; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    check_val("t2_frame_end", frame_l, 0);
    $display("frames 0x01,0x80 sent back-to-back");

    // Loads while busy are ignored.
    parallel_in = 8'hFF; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check_val($sformatf("t3_bit%0d", k), serial_l, 1);
      check_val($sformatf("t3_frame%0d", k), frame_l, 1);
      if (k >= 2 && k <= 6) begin
        parallel_in = 8'h00; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    check_val("t3_frame_end", frame_l, 0);
    step();
    check_val("t3_frame_idle", frame_l, 0);
    $display("frame 0xFF sent, busy loads ignored");

    // Asynchronous reset in the middle of a frame.
    d = 8'hAA;
    parallel_in = d; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check_val($sformatf("t4_bit%0d", k), serial_l, d[k-1]);
      if (k < 4) step();
    end
    #1 rst = 1'b1;
    #1;
    check_val("t4_async_frame", frame_l, 0);
    check_val("t4_async_serial", serial_l, 0);
    check_val("t4_async_done", done_l, 0);
    check_val("t4_async_ready", ready_l, 1);
    step();
    check_val("t4_held_frame", frame_l, 0);
    rst = 1'b0;
    d = 8'h55;
    parallel_in = d; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check_val($sformatf("t4_new_bit%0d", k), serial_l, d[k-1]);
      check_val($sformatf("t4_new_frame%0d", k), frame_l, 1);
      step();
    end
    check_val("t4_frame_end", frame_l, 0);
    $display("frame 0xAA aborted by reset, frame 0x55 sent");

    // Load held high from reset release with random words.
    rst = 1'b1;
    step();
    for (int i = 0; i < 5; i++) words[i] = 8'($urandom_range(0, 255));
    rst = 1'b0;
    parallel_in = words[0]; load = 1'b1;
    step();
    for (int f = 0; f < 4; f++) begin
      for (int k = 1; k <= 8; k++) begin
        check_val($sformatf("t5_w%0d_bit%0d", f, k), serial_l, words[f][k-1]);
        check_val($sformatf("t5_w%0d_frame%0d", f, k), frame_l, 1);
        check_val($sformatf("t5_w%0d_ready%0d", f, k), ready_l, (k == 8));
        parallel_in = (k == 8) ? words[f+1] : 8'($urandom_range(0, 255));
        step();
      end
      $display("stream word %0d = 0x%02h sent", f, words[f]);
    end
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
